pipelined_riscv_ex: RTL and testbench
=====================================

Name: pipelined_riscv_ex

Overview:
- Execute stage of the 5-stage pipelined RV32I core, directly downstream of the fetch/decode stage and control unit.
- Holds the ID/EX pipeline register and the EX/MEM pipeline register.
- Performs operand forwarding, ALU operation and branch/jump resolution.
- Detects load-use hazards and drives the stall/flush and PC-redirect signals back to fetch/decode.

Parameters:
XLEN, 32, datapath width
ALU_W, 4, width of alu_control encoding

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
reg_write_d  in  1  decode: writeback enable
result_src_d  in  2  decode: 00 ALU, 01 load data, 10 pc+4
mem_write_d  in  1  decode: store
jump_d  in  1  decode: jal/jalr
jalr_d  in  1  decode: jump is jalr (target from rs1)
branch_d  in  1  decode: conditional branch
alu_control_d  in  ALU_W  decode: ALU op
alu_src_d  in  1  decode: 1 selects immediate for operand B
funct3_d  in  3  decode: branch condition / mem size
rd1_d, rd2_d  in  XLEN  register file read data
pc_d, pc_plus4_d, imm_ext_d  in  XLEN  decode PC, PC+4, extended immediate
rs1_d, rs2_d, rd_d  in  5  register addresses
fwd_mem_val  in  XLEN  ALU result currently in MEM stage
fwd_wb_val  in  XLEN  result currently in WB stage
rd_w  in  5  WB destination
reg_write_w  in  1  WB writeback enable
stall_fd  out  1  hold PC and IF/ID register (load-use)
flush_fd  out  1  squash IF/ID (taken branch/jump)
pc_src_e  out  1  redirect fetch
pc_target_e  out  XLEN  redirect address
reg_write_m, mem_write_m  out  1  EX/MEM control
result_src_m  out  2  EX/MEM control
funct3_m  out  3  EX/MEM mem size
alu_result_m, write_data_m, pc_plus4_m  out  XLEN  EX/MEM data
rd_m  out  5  EX/MEM destination

Behaviour:
- Reset (reset_n low, asynchronous): every ID/EX and EX/MEM field cleared to 0, which is a NOP bubble. Outputs stall_fd=0, flush_fd=0, pc_src_e=0, pc_target_e=0.
- ID/EX register: captures all *_d inputs each rising edge. It loads zeros (bubble) when flush_e is high.
  - flush_e = stall_fd OR pc_src_e.
- Forwarding, operand A (B identical using rs2_e):
  - Priority 1: rs1_e!=0 && rs1_e==rd_m && reg_write_m -> alu_result_m.
  - Priority 2: rs1_e!=0 && rs1_e==rd_w && reg_write_w -> fwd_wb_val.
  - Otherwise: rd1_e.
  - MEM has priority over WB.
  - fwd_mem_val is ignored internally; it is kept for observability and must equal alu_result_m at top level.
- Operand B selection: srcB = alu_src_e ? imm_e : forwarded rs2 value.
- write_data_m captures the forwarded rs2 value, never the immediate.
- ALU encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt (signed), 0110 sltu
  - 0111 sll, 1000 srl, 1001 sra (shift amount = srcB[4:0])
  - All other codes give 0.
  - Arithmetic wraps mod 2^XLEN; no flags exported.
- Branch condition from funct3_e, compared on forwarded operands:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - Other funct3 values: not taken.
- pc_src_e = jump_e OR (branch_e AND cond). Combinational, same cycle the instruction is in EX.
- pc_target_e: jalr_e gives (forwarded rs1 + imm_e) & ~1; otherwise pc_e + imm_e.
- flush_fd = pc_src_e.
- Load-use hazard: stall_fd = (result_src_e==01) && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d). Combinational.
- Simultaneous stall and taken branch: the EX instruction is older and resolves. pc_src_e wins; flush_fd=1, and the ID/EX bubble is inserted either way.
- EX/MEM register: captures each edge, never stalls.
  - alu_result_m = ALU result; result_src 10 carries pc_plus4_m for the link value.
- x0 is never a forwarding source or hazard trigger.
- Reset asserted mid-operation: all in-flight EX/MEM contents lost immediately; the first edge after release captures the decode inputs normally.

Test Plan:
- Reset: hold reset_n=0, then release -> all *_m outputs 0; pc_src_e=0, stall_fd=0.
- Forward priority: add x5 (alu_result_m=7, rd_m=5), WB writes x5=9, EX reads rs1=5 with rd1=1, ALU add, imm=0, alu_src=1 -> alu_result_m=7 next cycle; with rd_m!=5 -> 9.
- Load-use: EX holds lw rd=3 (result_src 01), decode rs2_d=3 -> stall_fd=1 for exactly one cycle; next ID/EX is a bubble (reg_write_m=0 one cycle later).
- Branch: beq with equal operands, pc_d=0x100, imm=0x20 -> pc_src_e=1, pc_target_e=0x120, flush_fd=1, following ID/EX zeroed. Same with unequal operands -> pc_src_e=0.
- jalr: rs1=0x1003, imm=4 -> pc_target_e=0x1006; result_src_m=10 with pc_plus4_m forwarded into the EX/MEM stage.
- ALU ops: sra 0x80000000 by 4 -> 0xF8000000; sltu 1 vs 0xFFFFFFFF -> 1; slt -> 0; code 1111 -> 0.

Source files
------------

// File: rtl/pipelined_riscv_ex.sv
// Execute stage of the 5-stage RV32I pipeline: ID/EX and EX/MEM registers, operand forwarding,
// ALU, branch/jump resolution and load-use hazard detection feeding back to fetch/decode.
module pipelined_riscv_ex #(
    parameter int XLEN  = 32,
    parameter int ALU_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             reg_write_d,
    input  logic [1:0]       result_src_d,
    input  logic             mem_write_d,
    input  logic             jump_d,
    input  logic             jalr_d,
    input  logic             branch_d,
    input  logic [ALU_W-1:0] alu_control_d,
    input  logic             alu_src_d,
    input  logic [2:0]       funct3_d,
    input  logic [XLEN-1:0]  rd1_d,
    input  logic [XLEN-1:0]  rd2_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  pc_plus4_d,
    input  logic [XLEN-1:0]  imm_ext_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic [XLEN-1:0]  fwd_mem_val,
    input  logic [XLEN-1:0]  fwd_wb_val,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_w,
    output logic             stall_fd,
    output logic             flush_fd,
    output logic             pc_src_e,
    output logic [XLEN-1:0]  pc_target_e,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic [1:0]       result_src_m,
    output logic [2:0]       funct3_m,
    output logic [XLEN-1:0]  alu_result_m,
    output logic [XLEN-1:0]  write_data_m,
    output logic [XLEN-1:0]  pc_plus4_m,
    output logic [4:0]       rd_m
);

    localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SLTU = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_SRA  = ALU_W'(9);

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef struct packed {
        logic             reg_write;
        logic [1:0]       result_src;
        logic             mem_write;
        logic             jump;
        logic             jalr;
        logic             branch;
        logic [ALU_W-1:0] alu_control;
        logic             alu_src;
        logic [2:0]       funct3;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc_plus4;
        logic [XLEN-1:0]  imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
    } id_ex_t;

    id_ex_t          dec;
    id_ex_t          ex;
    logic            flush_e;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] jalr_sum;
    logic            branch_taken;

    assign dec = '{
        reg_write:   reg_write_d,
        result_src:  result_src_d,
        mem_write:   mem_write_d,
        jump:        jump_d,
        jalr:        jalr_d,
        branch:      branch_d,
        alu_control: alu_control_d,
        alu_src:     alu_src_d,
        funct3:      funct3_d,
        rd1:         rd1_d,
        rd2:         rd2_d,
        pc:          pc_d,
        pc_plus4:    pc_plus4_d,
        imm:         imm_ext_d,
        rs1:         rs1_d,
        rs2:         rs2_d,
        rd:          rd_d
    };

    // A load in EX whose destination is read by decode forces one bubble into EX.
    assign stall_fd = (ex.result_src == RESULT_LOAD) && (ex.rd != 5'd0) &&
                      ((ex.rd == rs1_d) || (ex.rd == rs2_d));
    assign flush_fd = pc_src_e;
    assign flush_e  = stall_fd | pc_src_e;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex <= '0;
        end else if (flush_e) begin
            ex <= '0;
        end else begin
            ex <= dec;
        end
    end

    // MEM beats WB because it holds the younger write to the same register.
    always_comb begin
        fwd_a = ex.rd1;
        if (ex.rs1 != 5'd0 && ex.rs1 == rd_m && reg_write_m) begin
            fwd_a = alu_result_m;
        end else if (ex.rs1 != 5'd0 && ex.rs1 == rd_w && reg_write_w) begin
            fwd_a = fwd_wb_val;
        end
    end

    always_comb begin
        fwd_b = ex.rd2;
        if (ex.rs2 != 5'd0 && ex.rs2 == rd_m && reg_write_m) begin
            fwd_b = alu_result_m;
        end else if (ex.rs2 != 5'd0 && ex.rs2 == rd_w && reg_write_w) begin
            fwd_b = fwd_wb_val;
        end
    end

    assign src_b = ex.alu_src ? ex.imm : fwd_b;

    always_comb begin
        alu_result = '0;
        case (ex.alu_control)
            ALU_ADD:  alu_result = fwd_a + src_b;
            ALU_SUB:  alu_result = fwd_a - src_b;
            ALU_AND:  alu_result = fwd_a & src_b;
            ALU_OR:   alu_result = fwd_a | src_b;
            ALU_XOR:  alu_result = fwd_a ^ src_b;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(src_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, fwd_a < src_b};
            ALU_SLL:  alu_result = fwd_a << src_b[4:0];
            ALU_SRL:  alu_result = fwd_a >> src_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(fwd_a) >>> src_b[4:0]);
            default:  alu_result = '0;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (ex.funct3)
            3'b000:  branch_taken = (fwd_a == fwd_b);
            3'b001:  branch_taken = (fwd_a != fwd_b);
            3'b100:  branch_taken = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  branch_taken = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  branch_taken = (fwd_a < fwd_b);
            3'b111:  branch_taken = (fwd_a >= fwd_b);
            default: branch_taken = 1'b0;
        endcase
    end

    assign jalr_sum    = fwd_a + ex.imm;
    assign pc_src_e    = ex.jump | (ex.branch & branch_taken);
    assign pc_target_e = ex.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex.pc + ex.imm);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            funct3_m     <= 3'b000;
            alu_result_m <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
            rd_m         <= 5'd0;
        end else begin
            reg_write_m  <= ex.reg_write;
            mem_write_m  <= ex.mem_write;
            result_src_m <= ex.result_src;
            funct3_m     <= ex.funct3;
            alu_result_m <= alu_result;
            write_data_m <= fwd_b;
            pc_plus4_m   <= ex.pc_plus4;
            rd_m         <= ex.rd;
        end
    end

    // The MEM forwarding path is taken from alu_result_m directly; the port only mirrors it.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (fwd_mem_val == alu_result_m);
        end
    end

endmodule

// File: tb/tb_pipelined_riscv_ex.sv
// Scoreboard testbench for the execute stage: expected EX/MEM contents are queued as each
// instruction is issued and compared when it reaches the MEM-side outputs.
module tb_pipelined_riscv_ex;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        reg_write_d;
    logic [1:0]  result_src_d;
    logic        mem_write_d;
    logic        jump_d;
    logic        jalr_d;
    logic        branch_d;
    logic [3:0]  alu_control_d;
    logic        alu_src_d;
    logic [2:0]  funct3_d;
    logic [31:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [31:0] fwd_mem_val, fwd_wb_val;
    logic [4:0]  rd_w;
    logic        reg_write_w;
    logic        stall_fd, flush_fd, pc_src_e;
    logic [31:0] pc_target_e;
    logic        reg_write_m, mem_write_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
    logic [4:0]  rd_m;

    assign fwd_mem_val = alu_result_m;

    pipelined_riscv_ex #(.XLEN(32), .ALU_W(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .reg_write_d(reg_write_d), .result_src_d(result_src_d), .mem_write_d(mem_write_d),
        .jump_d(jump_d), .jalr_d(jalr_d), .branch_d(branch_d), .alu_control_d(alu_control_d),
        .alu_src_d(alu_src_d), .funct3_d(funct3_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .fwd_mem_val(fwd_mem_val), .fwd_wb_val(fwd_wb_val), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .stall_fd(stall_fd), .flush_fd(flush_fd), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .funct3_m(funct3_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .pc_plus4_m(pc_plus4_m), .rd_m(rd_m)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_decode();
        reg_write_d = 1'b0; result_src_d = 2'b00; mem_write_d = 1'b0;
        jump_d = 1'b0; jalr_d = 1'b0; branch_d = 1'b0;
        alu_control_d = 4'b0000; alu_src_d = 1'b0; funct3_d = 3'b000;
        rd1_d = 32'd0; rd2_d = 32'd0; pc_d = 32'd0; pc_plus4_d = 32'd0; imm_ext_d = 32'd0;
        rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic use_imm, input logic [4:0] rd);
        clear_decode();
        reg_write_d = (rd != 5'd0); alu_control_d = op;
        rd1_d = a; rd2_d = b; imm_ext_d = imm; alu_src_d = use_imm; rd_d = rd;
    endtask

    task automatic push_exp(input string name, input logic [31:0] alu, input logic [31:0] wd,
                            input logic [4:0] rd, input logic rw, input logic [1:0] rs,
                            input logic [31:0] pc4);
        exp_t e;
        e.name = name; e.alu = alu; e.wd = wd; e.rd = rd; e.rw = rw; e.rs = rs; e.pc4 = pc4;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_decode();
        reg_write_d = 1'b1; result_src_d = 2'b01; rd_d = 5'd5; rs1_d = 5'd5; rd1_d = 32'h55;
        jump_d = 1'b1; pc_d = 32'h40; imm_ext_d = 32'h8;
        rd_w = 5'd0; reg_write_w = 1'b0; fwd_wb_val = 32'd0;
        repeat (3) tick();
        n_checks++;
        if ({reg_write_m, mem_write_m, result_src_m, funct3_m, alu_result_m, write_data_m, pc_plus4_m, rd_m} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem: got rw=%b mw=%b rs=%b f3=%b alu=%h wd=%h pc4=%h rd=%0d, expected all zero",
                     reg_write_m, mem_write_m, result_src_m, funct3_m, alu_result_m, write_data_m, pc_plus4_m, rd_m);
        end
        n_checks++;
        if ({pc_src_e, stall_fd, flush_fd, pc_target_e} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_ex: got pc_src=%b stall=%b flush=%b target=%h, expected 0 0 0 00000000",
                     pc_src_e, stall_fd, flush_fd, pc_target_e);
        end
        clear_decode();
        #2 reset_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({reg_write_m, alu_result_m, rd_m, pc_src_e, stall_fd} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got rw=%b alu=%h rd=%0d pc_src=%b stall=%b, expected zeros",
                     reg_write_m, alu_result_m, rd_m, pc_src_e, stall_fd);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        src;
        logic [31:0] res;
    } alu_vec_t;

    task automatic test_alu_back_to_back();
        alu_vec_t v[$];
        exp_t e;
        v.push_back('{4'b0000, 32'd5,         32'd7,         32'd0, 1'b0, 32'd12});
        v.push_back('{4'b0001, 32'd5,         32'd7,         32'd0, 1'b0, 32'hFFFF_FFFE});
        v.push_back('{4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 32'hF000_F000});
        v.push_back('{4'b0011, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'd0, 1'b0, 32'hFFFF_F0F0});
        v.push_back('{4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 1'b0, 32'h5555_5555});
        v.push_back('{4'b0101, 32'd1,         32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0});
        v.push_back('{4'b0101, 32'hFFFF_FFFF, 32'd1,         32'd0, 1'b0, 32'd1});
        v.push_back('{4'b0110, 32'd1,         32'hFFFF_FFFF, 32'd0, 1'b0, 32'd1});
        v.push_back('{4'b0111, 32'd1,         32'h0000_0021, 32'd0, 1'b0, 32'd2});
        v.push_back('{4'b1000, 32'h8000_0000, 32'd4,         32'd0, 1'b0, 32'h0800_0000});
        v.push_back('{4'b1001, 32'h8000_0000, 32'd4,         32'd0, 1'b0, 32'hF800_0000});
        v.push_back('{4'b1111, 32'd5,         32'd7,         32'd0, 1'b0, 32'd0});
        v.push_back('{4'b1010, 32'd5,         32'd7,         32'd0, 1'b0, 32'd0});
        v.push_back('{4'b0000, 32'h10,        32'hDEAD,      32'd4, 1'b1, 32'h14});
        v.push_back('{4'b1000, 32'hF0,        32'hFFFF,      32'd4, 1'b1, 32'h0F});
        for (int i = 0; i <= v.size(); i++) begin
            if (i < v.size()) begin
                set_alu(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].src, 5'(i + 1));
                push_exp($sformatf("alu[%0d]", i), v[i].res, v[i].b, 5'(i + 1), 1'b1, 2'b00, 32'd0);
            end else begin
                clear_decode();
            end
            tick();
            if (i >= 1) begin
                e = sb.pop_front();
                n_checks++;
                if ({alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m} !== {e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4}) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h, expected alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h",
                             e.name, alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m,
                             e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4);
                end
            end
        end
    endtask

    typedef struct {
        logic [4:0]  p_rd;
        logic [4:0]  wb_rd;
        logic        wb_en;
        logic [4:0]  q_rs1;
        logic [4:0]  q_rs2;
        logic [3:0]  q_op;
        logic [31:0] q_rd1;
        logic [31:0] q_rd2;
        logic [31:0] q_imm;
        logic        q_src;
        logic        q_store;
        logic [31:0] exp_alu;
        logic [31:0] exp_wd;
    } fwd_case_t;

    task automatic test_forwarding();
        fwd_case_t c[$];
        exp_t e;
        c.push_back('{5'd5, 5'd5, 1'b1, 5'd5, 5'd0, 4'b0000, 32'd1,  32'd0, 32'd0, 1'b1, 1'b0, 32'd7,    32'd0});
        c.push_back('{5'd8, 5'd5, 1'b1, 5'd5, 5'd0, 4'b0000, 32'd1,  32'd0, 32'd0, 1'b1, 1'b0, 32'd9,    32'd0});
        c.push_back('{5'd8, 5'd5, 1'b0, 5'd5, 5'd0, 4'b0000, 32'd1,  32'd0, 32'd0, 1'b1, 1'b0, 32'd1,    32'd0});
        c.push_back('{5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 4'b0000, 32'd1,  32'd0, 32'd0, 1'b1, 1'b0, 32'd1,    32'd0});
        c.push_back('{5'd5, 5'd5, 1'b1, 5'd0, 5'd5, 4'b0001, 32'd10, 32'd1, 32'd0, 1'b0, 1'b0, 32'd3,    32'd7});
        c.push_back('{5'd5, 5'd5, 1'b0, 5'd0, 5'd5, 4'b0000, 32'h40, 32'd1, 32'd8, 1'b1, 1'b1, 32'h48,   32'd7});
        c.push_back('{5'd8, 5'd5, 1'b1, 5'd0, 5'd5, 4'b0000, 32'd3,  32'd1, 32'd0, 1'b0, 1'b0, 32'd12,   32'd9});
        for (int i = 0; i < c.size(); i++) begin
            set_alu(4'b0000, 32'd3, 32'd4, 32'd0, 1'b0, c[i].p_rd);
            reg_write_d = 1'b1;
            push_exp($sformatf("fwd[%0d].producer", i), 32'd7, 32'd4, c[i].p_rd, 1'b1, 2'b00, 32'd0);
            tick();
            rd_w = c[i].wb_rd; reg_write_w = c[i].wb_en; fwd_wb_val = 32'd9;
            set_alu(c[i].q_op, c[i].q_rd1, c[i].q_rd2, c[i].q_imm, c[i].q_src, c[i].q_store ? 5'd0 : 5'd6);
            rs1_d = c[i].q_rs1; rs2_d = c[i].q_rs2; mem_write_d = c[i].q_store;
            funct3_d = c[i].q_store ? 3'b010 : 3'b000;
            push_exp($sformatf("fwd[%0d].consumer", i), c[i].exp_alu, c[i].exp_wd,
                     c[i].q_store ? 5'd0 : 5'd6, !c[i].q_store, 2'b00, 32'd0);
            for (int k = 0; k < 2; k++) begin
                tick();
                if (k == 0) clear_decode();
                e = sb.pop_front();
                n_checks++;
                if ({alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m} !== {e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4}) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h, expected alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h",
                             e.name, alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m,
                             e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4);
                end
            end
            if (c[i].q_store) begin
                n_checks++;
                if ({mem_write_m, funct3_m} !== {1'b1, 3'b010}) begin
                    n_fail++;
                    $display("[TB] FAIL fwd_store_ctrl: got mw=%b f3=%b, expected mw=1 f3=010", mem_write_m, funct3_m);
                end
            end
            rd_w = 5'd0; reg_write_w = 1'b0; fwd_wb_val = 32'd0;
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        set_alu(4'b0000, 32'h100, 32'd0, 32'd8, 1'b1, 5'd3);
        result_src_d = 2'b01; funct3_d = 3'b010;
        push_exp("load", 32'h108, 32'd0, 5'd3, 1'b1, 2'b01, 32'd0);
        tick();
        set_alu(4'b0000, 32'd1, 32'd0, 32'd0, 1'b0, 5'd4);
        rs2_d = 5'd3;
        #1;
        n_checks++;
        if ({stall_fd, flush_fd, pc_src_e} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL load_use_stall: got stall=%b flush=%b pc_src=%b, expected 1 0 0", stall_fd, flush_fd, pc_src_e);
        end
        push_exp("load_use_bubble", 32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 32'd0);
        push_exp("load_use_consumer", 32'hAC, 32'hAB, 5'd4, 1'b1, 2'b00, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) begin
                n_checks++;
                if ({stall_fd, funct3_m} !== {1'b0, 3'b010}) begin
                    n_fail++;
                    $display("[TB] FAIL load_use_one_cycle: got stall=%b f3=%b, expected stall=0 f3=010", stall_fd, funct3_m);
                end
                rd_w = 5'd3; reg_write_w = 1'b1; fwd_wb_val = 32'hAB;
            end
            if (k == 1) clear_decode();
            e = sb.pop_front();
            n_checks++;
            if ({alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m} !== {e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4}) begin
                n_fail++;
                $display("[TB] FAIL %s: got alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h, expected alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h",
                         e.name, alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m,
                         e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4);
            end
        end
        rd_w = 5'd0; reg_write_w = 1'b0; fwd_wb_val = 32'd0;
        set_alu(4'b0000, 32'h100, 32'd0, 32'd8, 1'b1, 5'd0);
        reg_write_d = 1'b1; result_src_d = 2'b01;
        tick();
        clear_decode();
        #1;
        n_checks++;
        if (stall_fd !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL load_use_x0: got stall=%b, expected 0", stall_fd);
        end
        tick();
        tick();
    endtask

    task automatic test_branch();
        exp_t e;
        logic [2:0]  f3 [7]  = '{3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b000};
        logic [31:0] ba [7]  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5};
        logic [31:0] bb [7]  = '{32'd6, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd6};
        logic        bt [7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int pass = 0; pass < 2; pass++) begin
            set_alu(4'b0001, 32'd5, (pass == 0) ? 32'd5 : 32'd6, 32'd0, 1'b0, 5'd0);
            branch_d = 1'b1; pc_d = 32'h100; imm_ext_d = 32'h20;
            push_exp($sformatf("beq[%0d]", pass), (pass == 0) ? 32'd0 : 32'hFFFF_FFFF,
                     (pass == 0) ? 32'd5 : 32'd6, 5'd0, 1'b0, 2'b00, 32'd0);
            tick();
            set_alu(4'b0000, 32'h33, 32'd0, 32'd0, 1'b0, 5'd9);
            #1;
            n_checks++;
            if ({pc_src_e, flush_fd, stall_fd} !== ((pass == 0) ? 3'b110 : 3'b000)) begin
                n_fail++;
                $display("[TB] FAIL beq_resolve[%0d]: got pc_src=%b flush=%b stall=%b", pass, pc_src_e, flush_fd, stall_fd);
            end
            if (pass == 0) begin
                n_checks++;
                if (pc_target_e !== 32'h120) begin
                    n_fail++;
                    $display("[TB] FAIL beq_target: got %h, expected 00000120", pc_target_e);
                end
                push_exp("beq_squashed", 32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 32'd0);
            end else begin
                push_exp("beq_fallthrough", 32'h33, 32'd0, 5'd9, 1'b1, 2'b00, 32'd0);
            end
            for (int k = 0; k < 2; k++) begin
                tick();
                if (k == 0) clear_decode();
                e = sb.pop_front();
                n_checks++;
                if ({alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m} !== {e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4}) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h, expected alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h",
                             e.name, alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m,
                             e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4);
                end
            end
        end
        for (int i = 0; i < 7; i++) begin
            clear_decode();
            branch_d = 1'b1; funct3_d = f3[i]; rd1_d = ba[i]; rd2_d = bb[i];
            pc_d = 32'h400; imm_ext_d = 32'hFFFF_FF00;
            tick();
            clear_decode();
            #1;
            n_checks++;
            if ({pc_src_e, flush_fd, pc_target_e} !== {bt[i], bt[i], 32'h300}) begin
                n_fail++;
                $display("[TB] FAIL branch_f3_%b: got pc_src=%b flush=%b target=%h, expected %b %b 00000300",
                         f3[i], pc_src_e, flush_fd, pc_target_e, bt[i], bt[i]);
            end
            tick();
        end
        set_alu(4'b0000, 32'd3, 32'd4, 32'd0, 1'b0, 5'd5);
        tick();
        clear_decode();
        branch_d = 1'b1; rs1_d = 5'd5; rd1_d = 32'd0; rd2_d = 32'd7; pc_d = 32'h100; imm_ext_d = 32'h8;
        tick();
        clear_decode();
        #1;
        n_checks++;
        if ({pc_src_e, pc_target_e} !== {1'b1, 32'h108}) begin
            n_fail++;
            $display("[TB] FAIL beq_forwarded: got pc_src=%b target=%h, expected 1 00000108", pc_src_e, pc_target_e);
        end
        tick();
        clear_decode();
        jump_d = 1'b1; result_src_d = 2'b01; reg_write_d = 1'b1; rd_d = 5'd3;
        pc_d = 32'h500; imm_ext_d = 32'h10;
        tick();
        clear_decode();
        rs1_d = 5'd3; reg_write_d = 1'b1; rd_d = 5'd9;
        #1;
        n_checks++;
        if ({stall_fd, flush_fd, pc_src_e, pc_target_e} !== {3'b111, 32'h510}) begin
            n_fail++;
            $display("[TB] FAIL stall_and_jump: got stall=%b flush=%b pc_src=%b target=%h, expected 1 1 1 00000510",
                     stall_fd, flush_fd, pc_src_e, pc_target_e);
        end
        tick();
        n_checks++;
        if ({stall_fd, pc_src_e} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL stall_and_jump_bubble: got stall=%b pc_src=%b, expected 0 0", stall_fd, pc_src_e);
        end
        clear_decode();
        tick();
        n_checks++;
        if ({reg_write_m, rd_m} !== 6'd0) begin
            n_fail++;
            $display("[TB] FAIL stall_and_jump_mem: got rw=%b rd=%0d, expected 0 0", reg_write_m, rd_m);
        end
    endtask

    task automatic test_jumps();
        exp_t e;
        logic [31:0] exp_target;
        for (int j = 0; j < 3; j++) begin
            if (j == 1) begin
                set_alu(4'b0000, 32'h2000, 32'd1, 32'd0, 1'b0, 5'd7);
                push_exp("jalr_producer", 32'h2001, 32'd1, 5'd7, 1'b1, 2'b00, 32'd0);
                tick();
            end
            clear_decode();
            jump_d = 1'b1; result_src_d = 2'b10; reg_write_d = 1'b1; rd_d = 5'd1;
            case (j)
                0: begin
                    jalr_d = 1'b1; rd1_d = 32'h1003; imm_ext_d = 32'd4; alu_src_d = 1'b1;
                    pc_d = 32'h200; pc_plus4_d = 32'h204; exp_target = 32'h1006;
                    push_exp("jalr", 32'h1007, 32'd0, 5'd1, 1'b1, 2'b10, 32'h204);
                end
                1: begin
                    jalr_d = 1'b1; rs1_d = 5'd7; rd1_d = 32'd0; imm_ext_d = 32'h10; alu_src_d = 1'b1;
                    pc_d = 32'h600; pc_plus4_d = 32'h604; exp_target = 32'h2010;
                    push_exp("jalr_forwarded", 32'h2011, 32'd0, 5'd1, 1'b1, 2'b10, 32'h604);
                end
                default: begin
                    pc_d = 32'h300; pc_plus4_d = 32'h304; imm_ext_d = 32'hFFFF_FFF0; exp_target = 32'h2F0;
                    push_exp("jal", 32'd0, 32'd0, 5'd1, 1'b1, 2'b10, 32'h304);
                end
            endcase
            tick();
            clear_decode();
            if (j == 1) begin
                e = sb.pop_front();
                n_checks++;
                if ({alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m} !== {e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4}) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h, expected alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h",
                             e.name, alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m,
                             e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4);
                end
            end
            #1;
            n_checks++;
            if ({pc_src_e, flush_fd, pc_target_e} !== {2'b11, exp_target}) begin
                n_fail++;
                $display("[TB] FAIL jump_target[%0d]: got pc_src=%b flush=%b target=%h, expected 1 1 %h",
                         j, pc_src_e, flush_fd, pc_target_e, exp_target);
            end
            push_exp($sformatf("jump_bubble[%0d]", j), 32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 32'd0);
            for (int k = 0; k < 2; k++) begin
                tick();
                e = sb.pop_front();
                n_checks++;
                if ({alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m} !== {e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4}) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h, expected alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h",
                             e.name, alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m,
                             e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        set_alu(4'b0000, 32'h11, 32'h22, 32'd0, 1'b0, 5'd6);
        tick();
        tick();
        n_checks++;
        if ({alu_result_m, rd_m} !== {32'h33, 5'd6}) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_before: got alu=%h rd=%0d, expected 00000033 6", alu_result_m, rd_m);
        end
        set_alu(4'b0000, 32'd1, 32'd2, 32'd0, 1'b0, 5'd7);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({reg_write_m, alu_result_m, write_data_m, rd_m, pc_src_e} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_async: got rw=%b alu=%h wd=%h rd=%0d pc_src=%b, expected zeros",
                     reg_write_m, alu_result_m, write_data_m, rd_m, pc_src_e);
        end
        sb.delete();
        tick();
        #2 reset_n = 1'b1;
        push_exp("reset_mid_first_after", 32'd3, 32'd2, 5'd7, 1'b1, 2'b00, 32'd0);
        tick();
        clear_decode();
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m} !== {e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4}) begin
            n_fail++;
            $display("[TB] FAIL %s: got alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h, expected alu=%h wd=%h rd=%0d rw=%b rs=%b pc4=%h",
                     e.name, alu_result_m, write_data_m, rd_m, reg_write_m, result_src_m, pc_plus4_m,
                     e.alu, e.wd, e.rd, e.rw, e.rs, e.pc4);
        end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_forwarding();
        test_load_use();
        test_branch();
        test_jumps();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
